// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed
    } scan_state_e;

    // Keymap flattened as 16 nibbles; nibble index = row * 4 + col.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
    localparam logic [63:0] KeyMap = 64'hDEF0_C987_B654_A321;

    // Hex value of the key at (row, col).
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KeyMap[base +: 4];
    endfunction

    // Lowest-index row that reads low; only meaningful when at least one row is low.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        if (!rows_n[0]) begin
            idx = 2'd0;
        end else if (!rows_n[1]) begin
            idx = 2'd1;
        end else if (!rows_n[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
    parameter int unsigned     Width    = 4,
    parameter logic [Width-1:0] ResetVal = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stage1_q;
    logic [Width-1:0] stage2_q;

    // Two back-to-back flops; reset to the idle (pulled-up) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1_q <= ResetVal;
            stage2_q <= ResetVal;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, debounce, press/release tracking and a
// four-digit accumulator of accepted keys.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    input  logic        clear,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] key_accum
);

    localparam int unsigned TickW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_DIV - 1);
    // DEBOUNCE_SCANS of 0 behaves like 1.
    localparam logic [CntW-1:0]  DebTarget = (DEBOUNCE_SCANS > 1) ? CntW'(DEBOUNCE_SCANS)
                                                                   : CntW'(1);

    logic [3:0]       row_sync;
    logic [TickW-1:0] tick_cnt_q;
    logic             tick;

    scan_state_e      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CntW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [CntW-1:0]  rel_cnt_q, rel_cnt_d;
    logic [CntW-1:0]  deb_inc, rel_inc;
    logic             row_low;
    logic             accept;
    logic [3:0]       accept_code;

    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic [15:0]      key_accum_q;

    sync_2ff #(
        .Width    (4),
        .ResetVal (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_sync)
    );

    assign tick = (tick_cnt_q == TickLast);

    // Free-running dwell counter; wraps on tick regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TickW'(1);
        end
    end

    // FSM, column, latched row and debounce/release counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StScan;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            deb_cnt_q <= deb_cnt_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    // Next-state logic; every transition is gated by tick.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        deb_cnt_d = deb_cnt_q;
        rel_cnt_d = rel_cnt_q;
        accept    = 1'b0;
        row_low   = ~row_sync[row_q];
        deb_inc   = deb_cnt_q + CntW'(1);
        rel_inc   = rel_cnt_q + CntW'(1);

        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (row_sync != 4'b1111) begin
                        // Latch the key; the column stays driven from here on.
                        row_d     = first_low_row(row_sync);
                        deb_cnt_d = CntW'(1);
                        rel_cnt_d = '0;
                        if (DebTarget == CntW'(1)) begin
                            state_d = StPressed;
                            accept  = 1'b1;
                        end else begin
                            state_d = StDebounce;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (row_low) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc >= DebTarget) begin
                            state_d   = StPressed;
                            rel_cnt_d = '0;
                            accept    = 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate and keep scanning.
                        state_d   = StScan;
                        deb_cnt_d = '0;
                        col_d     = col_q + 2'd1;
                    end
                end
                StPressed: begin
                    if (!row_low) begin
                        if (rel_inc >= DebTarget) begin
                            state_d   = StScan;
                            rel_cnt_d = '0;
                            deb_cnt_d = '0;
                            col_d     = col_q + 2'd1;
                        end else begin
                            rel_cnt_d = rel_inc;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = StScan;
                end
            endcase
        end

        accept_code = key_lookup(row_d, col_q);
    end

    // Accepted-key outputs; clear takes priority over the accumulator shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_accum_q <= 16'h0000;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= accept_code;
            end
            if (clear) begin
                key_accum_q <= 16'h0000;
            end else if (accept) begin
                key_accum_q <= {key_accum_q[11:0], accept_code};
            end
        end
    end

    // Output drive: one-hot-low column, held flag from the registered state.
    always_comb begin
        col_n     = ~(4'b0001 << col_q);
        key_held  = (state_q == StPressed);
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_accum = key_accum_q;
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed self-checking bench for hex_keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
module tb_hex_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  row_n;
    logic        clear;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_accum;

    logic [15:0] keys;       // pressed keys, index = row * 4 + col
    int          n_checks;
    int          n_fail;
    int          valid_cnt;
    int          v0;

    hex_keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .clear     (clear),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_accum (key_accum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    // Count key_valid pulses.
    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stop at the first negedge with key_valid high (bounded).
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, key_valid}, 32'd1);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, key_held}, 32'd0);
    endtask

    task automatic wait_col(input logic [3:0] want, input string tag);
        int n;
        n = 0;
        while (col_n !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {28'd0, col_n}, {28'd0, want});
    endtask

    task automatic press_accept(input int idx, input logic [3:0] code, input string tag);
        keys = 16'h0;
        keys[idx] = 1'b1;
        wait_valid({tag, "_valid"});
        check_eq({tag, "_code"}, {28'd0, key_code}, {28'd0, code});
        keys = 16'h0;
        wait_release({tag, "_release"});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        valid_cnt = 0;
        keys      = 16'h0;
        clear     = 1'b0;
        reset     = 1'b1;

        // Reset state and column rotation.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_col", {28'd0, col_n}, 32'he);
        check_eq("rst_code", {28'd0, key_code}, 32'd0);
        check_eq("rst_valid", {31'd0, key_valid}, 32'd0);
        check_eq("rst_held", {31'd0, key_held}, 32'd0);
        check_eq("rst_accum", {16'd0, key_accum}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("rot_c1", {28'd0, col_n}, 32'hd);
        repeat (4) @(negedge clk);
        check_eq("rot_c2", {28'd0, col_n}, 32'hb);
        repeat (4) @(negedge clk);
        check_eq("rot_c3", {28'd0, col_n}, 32'h7);
        repeat (4) @(negedge clk);
        check_eq("rot_c0", {28'd0, col_n}, 32'he);

        // Key 5 held steady.
        v0 = valid_cnt;
        keys[5] = 1'b1;
        wait_valid("k5_valid");
        check_eq("k5_code", {28'd0, key_code}, 32'h5);
        check_eq("k5_accum", {16'd0, key_accum}, 32'h0005);
        repeat (20) @(negedge clk);
        check_eq("k5_held", {31'd0, key_held}, 32'd1);
        check_eq("k5_col_held", {28'd0, col_n}, 32'hd);
        check_eq("k5_one_pulse", valid_cnt - v0, 32'd1);
        // Release on a negedge right after a tick: sync 2, then two release ticks.
        wait_col(4'hd, "k5_sync_col");
        while (dut.tick_cnt_q !== 2'd0) @(negedge clk);
        keys = 16'h0;
        repeat (7) @(negedge clk);
        check_eq("k5_held_late", {31'd0, key_held}, 32'd1);
        @(negedge clk);
        check_eq("k5_dropped", {31'd0, key_held}, 32'd0);
        check_eq("k5_col_adv", {28'd0, col_n}, 32'hb);

        // Key 9 for a single tick: bounce, no acceptance.
        v0 = valid_cnt;
        wait_col(4'h7, "b9_c3");
        wait_col(4'hb, "b9_c2");
        keys[10] = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("b9_col_hold", {28'd0, col_n}, 32'hb);
        keys = 16'h0;
        repeat (4) @(negedge clk);
        check_eq("b9_scan_c3", {28'd0, col_n}, 32'h7);
        check_eq("b9_held", {31'd0, key_held}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("b9_scan_c0", {28'd0, col_n}, 32'he);
        check_eq("b9_no_valid", valid_cnt - v0, 32'd0);
        check_eq("b9_accum", {16'd0, key_accum}, 32'h0005);

        // Keys 1, 2, A, F then 3.
        press_accept(0, 4'h1, "s1");
        press_accept(1, 4'h2, "s2");
        press_accept(3, 4'hA, "sA");
        press_accept(13, 4'hF, "sF");
        check_eq("seq_12af", {16'd0, key_accum}, 32'h12af);
        press_accept(2, 4'h3, "s3");
        check_eq("seq_2af3", {16'd0, key_accum}, 32'h2af3);

        // Keys 4 and 0 together with clear across the accept.
        v0 = valid_cnt;
        clear = 1'b1;
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        wait_valid("k40_valid");
        check_eq("k40_code", {28'd0, key_code}, 32'h4);
        check_eq("k40_accum", {16'd0, key_accum}, 32'h0000);
        keys = 16'h0;
        wait_release("k40_release");
        clear = 1'b0;
        @(negedge clk);
        check_eq("k40_one_pulse", valid_cnt - v0, 32'd1);
        check_eq("k40_accum_after", {16'd0, key_accum}, 32'h0000);

        // Reset while key E held.
        keys[14] = 1'b1;
        wait_valid("ke_valid");
        check_eq("ke_code", {28'd0, key_code}, 32'he);
        check_eq("ke_accum", {16'd0, key_accum}, 32'h000e);
        repeat (3) @(negedge clk);
        check_eq("ke_held", {31'd0, key_held}, 32'd1);
        v0 = valid_cnt;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("ke_rst_valid", {31'd0, key_valid}, 32'd0);
        end
        reset = 1'b0;
        check_eq("ke_rst_held", {31'd0, key_held}, 32'd0);
        check_eq("ke_rst_accum", {16'd0, key_accum}, 32'h0000);
        check_eq("ke_rst_col", {28'd0, col_n}, 32'he);
        check_eq("ke_rst_nopulse", valid_cnt - v0, 32'd0);
        wait_valid("ke_redetect");
        check_eq("ke_re_code", {28'd0, key_code}, 32'he);
        check_eq("ke_re_accum", {16'd0, key_accum}, 32'h000e);
        keys = 16'h0;
        wait_release("ke_release");
        check_eq("ke_one_pulse", valid_cnt - v0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
